// File: rtl/gray_level_transform_pipe.sv
// Two-stage gray-level transform (bypass / saturating gain / programmable LUT / invert), 2-cycle latency.
// Backpressure: every pipeline register holds while m_valid & !m_ready; s_ready = !m_valid | m_ready.
module gray_level_transform_pipe #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        mode,
  input  logic [GAIN_W-1:0] gain,
  input  logic              lut_we,
  input  logic [IN_W-1:0]   lut_waddr,
  input  logic [OUT_W-1:0]  lut_wdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_gray,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_gray
);

  localparam int DEPTH = 1 << IN_W;
  localparam int PW    = IN_W + GAIN_W;
  // One spare bit above the product or the output width so the saturation limit is representable.
  localparam int WW    = ((PW > OUT_W) ? PW : OUT_W) + 1;

  logic              en;
  logic              v1;
  logic [IN_W-1:0]   g1;
  logic [1:0]        mode1;
  logic [GAIN_W-1:0] gain1;
  logic [OUT_W-1:0]  lut [DEPTH];
  logic [OUT_W-1:0]  f_dat;
  logic [IN_W-1:0]   inv_g;
  logic [WW-1:0]     prod;
  logic [WW-1:0]     sat_lim;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1    <= 1'b0;
      g1    <= '0;
      mode1 <= '0;
      gain1 <= '0;
    end else if (en) begin
      v1    <= s_valid;
      g1    <= s_gray;
      mode1 <= mode;
      gain1 <= gain;
    end
  end

  always_comb begin
    inv_g   = ~g1;
    prod    = WW'(g1) * WW'(gain1);
    sat_lim = WW'(1) << OUT_W;
    f_dat   = '0;
    case (mode1)
      2'd0:    f_dat = OUT_W'(g1);
      2'd1:    f_dat = (prod >= sat_lim) ? '1 : OUT_W'(prod);
      2'd2:    f_dat = lut[g1];
      default: f_dat = OUT_W'(inv_g);
    endcase
  end

  // m_gray only loads on a real sample so bubbles leave the last level on the bus.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_valid <= 1'b0;
      m_gray  <= '0;
    end else if (en) begin
      m_valid <= v1;
      if (v1) m_gray <= f_dat;
    end
  end

  // Writes ignore the handshake; a same-cycle read of the written entry sees the old word.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_gray_level_transform_pipe.sv
// Bench for gray_level_transform_pipe: directed scenarios plus a randomized run against a
// sample-level model; a 12-bit-output instance shares the stimulus to cover saturation.
module tb_gray_level_transform_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  gain = '0;
  logic        lut_we = 1'b0;
  logic [7:0]  lut_waddr = '0;
  logic [15:0] lut_wdata = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_gray = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_gray;
  logic        s_ready12;
  logic        m_valid12;
  logic [11:0] m_gray12;

  always #5 clk = ~clk;

  gray_level_transform_pipe #(.IN_W(8), .OUT_W(16), .GAIN_W(8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .gain(gain),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_gray(s_gray),
    .m_valid(m_valid), .m_ready(m_ready), .m_gray(m_gray)
  );

  gray_level_transform_pipe #(.IN_W(8), .OUT_W(12), .GAIN_W(8)) dut12 (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .gain(gain),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata[11:0]),
    .s_valid(s_valid), .s_ready(s_ready12), .s_gray(s_gray),
    .m_valid(m_valid12), .m_ready(m_ready), .m_gray(m_gray12)
  );

  int vectors = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int g; int md; int gn; } beat_t;
  beat_t sbq[$];
  int    model_lut[256];

  function automatic int xform(beat_t b, int outw);
    int     full = (1 << outw) - 1;
    longint p;
    case (b.md)
      0: return b.g & full;
      1: begin
        p = longint'(b.g) * longint'(b.gn);
        return (p > full) ? full : int'(p);
      end
      2: return model_lut[b.g] & full;
      default: return 255 - b.g;
    endcase
  endfunction

  int e16, e12, last16, last12;
  bit presented;
  bit pend_we;
  int pend_a, pend_d;
  beat_t nb;

  // A sample's value is fixed when it first appears on m_gray, using the LUT as it stood before
  // that edge's write; writes are therefore applied one sampling point late.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_m_gray", m_gray, 0);
      check("rst_m_valid12", m_valid12, 0);
      sbq.delete();
      presented = 0;
      last16 = 0;
      last12 = 0;
      pend_we = 0;
      foreach (model_lut[i]) model_lut[i] = 0;
    end else begin
      check("s_ready_rule", s_ready, !m_valid || m_ready);
      check("m_valid12_match", m_valid12, m_valid);
      if (m_valid) begin
        check("out_has_pending_sample", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          if (!presented) begin
            e16 = xform(sbq[0], 16);
            e12 = xform(sbq[0], 12);
            presented = 1;
          end
          check("m_gray", m_gray, e16);
          check("m_gray12", m_gray12, e12);
        end
      end else begin
        check("m_gray_hold", m_gray, last16);
        check("m_gray12_hold", m_gray12, last12);
      end
      last16 = m_gray;
      last12 = m_gray12;
      if (m_valid && m_ready && sbq.size() != 0) begin
        void'(sbq.pop_front());
        presented = 0;
      end
      if (s_valid && s_ready) begin
        nb.g = s_gray; nb.md = mode; nb.gn = gain;
        sbq.push_back(nb);
      end
      if (pend_we) model_lut[pend_a] = pend_d;
      pend_we = lut_we;
      pend_a  = lut_waddr;
      pend_d  = lut_wdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  int in_g[$], in_m[$], in_k[$], got[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lut_write(input int a, input int d);
    lut_we = 1'b1; lut_waddr = 8'(a); lut_wdata = 16'(d);
    tick();
    lut_we = 1'b0;
  endtask

  task automatic one_beat(input int g, input int md, input int gn,
                          output int r16, output int r12, output int lat);
    int cnt = 0;
    m_ready = 1'b1; s_valid = 1'b1; s_gray = 8'(g); mode = 2'(md); gain = 8'(gn);
    #1;
    while (!s_ready && cnt < 20) begin tick(); #1; cnt++; end
    tick();
    s_valid = 1'b0;
    lat = 1;
    #1;
    while (!m_valid && lat < 20) begin tick(); lat++; #1; end
    check("beat_arrived", m_valid, 1);
    r16 = m_gray;
    r12 = m_gray12;
    tick();
  endtask

  task automatic stream(input int stall_after, input int stall_len);
    int idx = 0, cyc = 0, stall_left = 0;
    int n = in_g.size();
    got.delete();
    while ((idx < n || got.size() < n) && cyc < 300) begin
      m_ready = (stall_left == 0);
      s_valid = (idx < n);
      if (idx < n) begin
        s_gray = 8'(in_g[idx]); mode = 2'(in_m[idx]); gain = 8'(in_k[idx]);
      end
      #1;
      if (!m_ready) check("stall_s_ready", s_ready, 0);
      if (m_valid && m_ready) begin
        got.push_back(int'(m_gray));
        if (got.size() == stall_after) stall_left = stall_len;
      end
      if (s_valid && s_ready) idx++;
      tick();
      cyc++;
      if (!m_ready && stall_left > 0) stall_left--;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("stream_count", got.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int r16, r12, lat, a;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_s_ready", s_ready, 1);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_gray", m_gray, 0);
    tick();

    // Bypass and 2-cycle latency
    one_beat(8'hA5, 0, 0, r16, r12, lat);
    check("bypass_a5", r16, 16'h00A5);
    check("bypass_latency", lat, 2);

    // Linear gain, and saturation at 12-bit width
    one_beat(200, 1, 2, r16, r12, lat);
    check("gain_200x2", r16, 400);
    check("gain_200x2_w12", r12, 400);
    one_beat(255, 1, 255, r16, r12, lat);
    check("gain_255x255", r16, 65025);
    check("gain_sat_w12", r12, 12'hFFF);

    // LUT
    lut_write(10, 1234);
    lut_write(255, 1420);
    in_g = '{10, 255, 0}; in_m = '{2, 2, 2}; in_k = '{0, 0, 0};
    stream(0, 0);
    check("lut_10", got[0], 1234);
    check("lut_255", got[1], 1420);
    check("lut_0", got[2], 0);

    // Write lut[10] in the very cycle the stage-1 sample reads it
    m_ready = 1'b1; s_valid = 1'b1; s_gray = 8'd10; mode = 2'd2;
    tick();
    s_valid = 1'b0;
    lut_we = 1'b1; lut_waddr = 8'd10; lut_wdata = 16'd99;
    tick();
    lut_we = 1'b0;
    #1;
    check("lut_rw_valid", m_valid, 1);
    check("lut_rw_old", m_gray, 1234);
    tick();
    one_beat(10, 2, 0, r16, r12, lat);
    check("lut_rw_new", r16, 99);

    // Inversion with a 5-cycle stall after the 2nd output
    in_g.delete(); in_m.delete(); in_k.delete();
    for (int i = 0; i < 8; i++) begin in_g.push_back(i); in_m.push_back(3); in_k.push_back(0); end
    stream(2, 5);
    for (int i = 0; i < 8 && i < got.size(); i++) check("invert_seq", got[i], 255 - i);

    // Mode change between consecutive beats
    in_g = '{50, 50}; in_m = '{0, 1}; in_k = '{3, 3};
    stream(0, 0);
    check("mode_switch_0", got[0], 50);
    check("mode_switch_1", got[1], 150);

    // Reset with two samples in flight
    m_ready = 1'b0; s_valid = 1'b1; mode = 2'd0; s_gray = 8'd1;
    tick();
    s_gray = 8'd2;
    tick();
    s_valid = 1'b0;
    #1;
    check("inflight_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_m_gray", m_gray, 0);
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_no_stale", m_valid, 0);
      check("post_rst_s_ready", s_ready, 1);
      tick();
    end
    one_beat(10, 2, 0, r16, r12, lat);
    check("post_rst_lut10", r16, 0);
    a = $urandom_range(0, 255);
    one_beat(a, 2, 0, r16, r12, lat);
    check("post_rst_lut_rand", r16, 0);

    // Randomized traffic with LUT writes and backpressure
    for (int c = 0; c < 3000; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_gray    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      mode      = 2'($urandom);
      gain      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      m_ready   = ($urandom_range(0, 3) != 0);
      lut_we    = ($urandom_range(0, 5) == 0);
      lut_waddr = 8'($urandom_range(0, 15));
      lut_wdata = 16'($urandom);
      tick();
    end
    s_valid = 1'b0; lut_we = 1'b0; m_ready = 1'b1;
    repeat (6) tick();
    check("drain_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
